// File: rtl/lap_ctl.sv
// lap_ctl: stopwatch run/stop/lap controller with a small lap memory.
// Events are single-cycle key pulses, resolved with priority clear > start_stop > lap.
// In VIEW the display shows stored laps; otherwise it follows the live counters.
// Optional feature: define LAP_BEEP_EN to enable the lap-capture beep timer.
`timescale 1ns/1ps
module lap_ctl #(
  parameter int unsigned LAP_DEPTH = 4,
  parameter int unsigned BEEP_MS   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pls1k,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  input  logic [6:0] hcnt,
  input  logic [6:0] tcnt,
  input  logic [5:0] mcnt,
  input  logic [5:0] scnt,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [6:0] disp_h,
  output logic [6:0] disp_t,
  output logic [5:0] disp_m,
  output logic [5:0] disp_s,
  output logic [3:0] lap_cnt,
  output logic [2:0] view_idx,
  output logic       lap_full,
  output logic       lap_ovf,
  output logic [1:0] state,
  output logic       beep
);

  localparam int unsigned IdxW   = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int unsigned EntryW = 26;
  localparam logic [3:0]  DepthC = 4'(LAP_DEPTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2,
    StView = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              cnt_en_q;
  logic              cnt_clr_q, cnt_clr_d;
  logic [3:0]        lap_cnt_q, lap_cnt_d;
  logic [2:0]        view_idx_q, view_idx_d;
  logic              lap_ovf_q, lap_ovf_d;
  logic              lap_wr;
  logic [EntryW-1:0] lap_mem [LAP_DEPTH];
  logic [EntryW-1:0] view_entry;

  // Priority-resolved events: at most one is acted on per cycle.
  logic ev_clear, ev_ss, ev_lap;
  assign ev_clear = clear;
  assign ev_ss    = start_stop & ~clear;
  assign ev_lap   = lap & ~clear & ~start_stop;

  // Last valid entry reached while stepping through the laps.
  logic view_last;
  assign view_last = ({1'b0, view_idx_q} == (lap_cnt_q - 4'd1));

  // Next-state, lap bookkeeping and capture strobe.
  always_comb begin
    state_d    = state_q;
    lap_cnt_d  = lap_cnt_q;
    view_idx_d = view_idx_q;
    lap_ovf_d  = lap_ovf_q;
    cnt_clr_d  = 1'b0;
    lap_wr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ev_clear) begin
          cnt_clr_d = 1'b1;
        end else if (ev_ss) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (ev_ss) begin
          state_d = StStop;
        end else if (ev_lap) begin
          if (lap_cnt_q == DepthC) begin
            lap_ovf_d = 1'b1;
          end else begin
            lap_wr    = 1'b1;
            lap_cnt_d = lap_cnt_q + 4'd1;
          end
        end
      end
      StStop: begin
        if (ev_clear) begin
          state_d    = StIdle;
          cnt_clr_d  = 1'b1;
          lap_cnt_d  = 4'd0;
          lap_ovf_d  = 1'b0;
          view_idx_d = 3'd0;
        end else if (ev_ss) begin
          state_d = StRun;
        end else if (ev_lap && (lap_cnt_q != 4'd0)) begin
          state_d    = StView;
          view_idx_d = 3'd0;
        end
      end
      StView: begin
        if (ev_clear) begin
          state_d    = StIdle;
          cnt_clr_d  = 1'b1;
          lap_cnt_d  = 4'd0;
          lap_ovf_d  = 1'b0;
          view_idx_d = 3'd0;
        end else if (ev_ss) begin
          state_d    = StRun;
          view_idx_d = 3'd0;
        end else if (ev_lap) begin
          if (view_last) begin
            state_d    = StStop;
            view_idx_d = 3'd0;
          end else begin
            view_idx_d = view_idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      lap_cnt_q  <= 4'd0;
      view_idx_q <= 3'd0;
      lap_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_en_q   <= (state_d == StRun);
      cnt_clr_q  <= cnt_clr_d;
      lap_cnt_q  <= lap_cnt_d;
      view_idx_q <= view_idx_d;
      lap_ovf_q  <= lap_ovf_d;
    end
  end

  // Lap memory write; contents survive clear and reset, stale entries are never shown.
  always_ff @(posedge clk) begin
    if (lap_wr) begin
      lap_mem[lap_cnt_q[IdxW-1:0]] <= {hcnt, tcnt, mcnt, scnt};
    end
  end

  // Display source select: stored lap in VIEW, live counters otherwise.
  always_comb begin
    view_entry = lap_mem[view_idx_q[IdxW-1:0]];
    if (state_q == StView) begin
      {disp_h, disp_t, disp_m, disp_s} = view_entry;
    end else begin
      {disp_h, disp_t, disp_m, disp_s} = {hcnt, tcnt, mcnt, scnt};
    end
  end

  assign state    = state_q;
  assign cnt_en   = cnt_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign lap_cnt  = lap_cnt_q;
  assign view_idx = view_idx_q;
  assign lap_ovf  = lap_ovf_q;
  assign lap_full = (lap_cnt_q == DepthC);

`ifdef LAP_BEEP_EN
  localparam logic [7:0] BeepLen = 8'(BEEP_MS);

  logic       pls_q;
  logic       pls_rise;
  logic       beep_q, beep_d;
  logic [7:0] beep_cnt_q, beep_cnt_d;

  assign pls_rise = pls1k & ~pls_q;

  // Beep timer: an accepted capture (re)starts it, pls1k rising edges run it down.
  always_comb begin
    beep_d     = beep_q;
    beep_cnt_d = beep_cnt_q;
    if (lap_wr) begin
      beep_d     = 1'b1;
      beep_cnt_d = 8'd0;
    end else if (beep_q && pls_rise) begin
      if (beep_cnt_q == BeepLen - 8'd1) begin
        beep_d     = 1'b0;
        beep_cnt_d = 8'd0;
      end else begin
        beep_cnt_d = beep_cnt_q + 8'd1;
      end
    end
  end

  // Beep and pls1k edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pls_q      <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt_q <= 8'd0;
    end else begin
      pls_q      <= pls1k;
      beep_q     <= beep_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign beep = beep_q;
`else
  logic unused_beep_cfg;
  assign unused_beep_cfg = ^{pls1k, 8'(BEEP_MS)};
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_lap_ctl.sv
// tb_lap_ctl: directed stimulus with a scoreboard queue and a separate monitor.
// Build with +define+LAP_BEEP_EN to include the beep timing checks.
`timescale 1ns/1ps
module tb_lap_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pls1k = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [6:0] hcnt = '0;
  logic [6:0] tcnt = '0;
  logic [5:0] mcnt = '0;
  logic [5:0] scnt = '0;
  logic       cnt_en, cnt_clr, lap_full, lap_ovf, beep;
  logic [6:0] disp_h, disp_t;
  logic [5:0] disp_m, disp_s;
  logic [3:0] lap_cnt;
  logic [2:0] view_idx;
  logic [1:0] state;

  lap_ctl #(.LAP_DEPTH(4), .BEEP_MS(50)) dut (
    .clk(clk), .rst(rst), .pls1k(pls1k),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .hcnt(hcnt), .tcnt(tcnt), .mcnt(mcnt), .scnt(scnt),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .disp_h(disp_h), .disp_t(disp_t), .disp_m(disp_m), .disp_s(disp_s),
    .lap_cnt(lap_cnt), .view_idx(view_idx), .lap_full(lap_full), .lap_ovf(lap_ovf),
    .state(state), .beep(beep)
  );

  always #5 clk = ~clk;

  // Fast stand-in for the 1 kHz tick: 8-cycle period, toggling just after negedge.
  initial forever begin
    repeat (4) @(negedge clk);
    #1 pls1k = ~pls1k;
  end

  typedef enum int {FState, FEn, FClr, FLapCnt, FFull, FOvf, FView,
                    FDispH, FDispT, FDispM, FDispS, FBeep} field_e;
  typedef struct {
    string       name;
    field_e      fld;
    int unsigned exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  event chk_ev;

  function automatic logic [31:0] read_field(input field_e f);
    case (f)
      FState:  return 32'(state);
      FEn:     return 32'(cnt_en);
      FClr:    return 32'(cnt_clr);
      FLapCnt: return 32'(lap_cnt);
      FFull:   return 32'(lap_full);
      FOvf:    return 32'(lap_ovf);
      FView:   return 32'(view_idx);
      FDispH:  return 32'(disp_h);
      FDispT:  return 32'(disp_t);
      FDispM:  return 32'(disp_m);
      FDispS:  return 32'(disp_s);
      default: return 32'(beep);
    endcase
  endfunction

  // Monitor: drains every pending expectation whenever the outputs are presented.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = read_field(e.fld);
        total++;
        if (act !== 32'(e.exp)) begin
          bad++;
          $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input string n, input field_e f, input int unsigned v);
    exp_t e;
    e.name = n;
    e.fld  = f;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic expect_disp(input string n, input int unsigned h, input int unsigned t,
                             input int unsigned m, input int unsigned s);
    expect_v({n, "_h"}, FDispH, h);
    expect_v({n, "_t"}, FDispT, t);
    expect_v({n, "_m"}, FDispM, m);
    expect_v({n, "_s"}, FDispS, s);
  endtask

  task automatic sample();
    @(negedge clk);
    ->chk_ev;
    #1;
  endtask

  task automatic sample_now();
    ->chk_ev;
    #1;
  endtask

  task automatic pulse(input logic s, input logic c, input logic l);
    @(posedge clk);
    #1 start_stop = s; clear = c; lap = l;
    @(posedge clk);
    #1 start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic set_live(input int unsigned h, input int unsigned t,
                          input int unsigned m, input int unsigned s);
    hcnt = 7'(h);
    tcnt = 7'(t);
    mcnt = 6'(m);
    scnt = 6'(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_live(1, 2, 3, 4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state and live display in IDLE.
    expect_v("rst_state", FState, 0);
    expect_v("rst_en", FEn, 0);
    expect_v("rst_clr", FClr, 0);
    expect_v("rst_lapcnt", FLapCnt, 0);
    expect_v("rst_full", FFull, 0);
    expect_v("rst_ovf", FOvf, 0);
    expect_v("rst_view", FView, 0);
    expect_v("rst_beep", FBeep, 0);
    expect_disp("idle_disp", 1, 2, 3, 4);
    sample();

    // IDLE: lap ignored, clear pulses cnt_clr for one cycle.
    pulse(0, 0, 1);
    expect_v("idle_lap_state", FState, 0);
    expect_v("idle_lap_cnt", FLapCnt, 0);
    sample();
    pulse(0, 1, 0);
    expect_v("idle_clr_pulse", FClr, 1);
    expect_v("idle_clr_state", FState, 0);
    sample();
    expect_v("idle_clr_drop", FClr, 0);
    sample();

    // start_stop: outputs change only after the event edge.
    repeat (4) @(posedge clk);
    #1 start_stop = 1'b1;
    expect_v("pre_run_state", FState, 0);
    expect_v("pre_run_en", FEn, 0);
    sample();
    @(posedge clk);
    #1 start_stop = 1'b0;
    expect_v("run_state", FState, 1);
    expect_v("run_en", FEn, 1);
    sample();

    // First capture, clear ignored in RUN.
    set_live(37, 12, 5, 9);
    pulse(0, 0, 1);
    expect_v("cap1_cnt", FLapCnt, 1);
    expect_v("cap1_full", FFull, 0);
    expect_v("cap1_state", FState, 1);
`ifdef LAP_BEEP_EN
    expect_v("cap1_beep", FBeep, 1);
`else
    expect_v("cap1_beep", FBeep, 0);
`endif
    sample();
    pulse(0, 1, 0);
    expect_v("run_clr_state", FState, 1);
    expect_v("run_clr_pulse", FClr, 0);
    expect_v("run_clr_cnt", FLapCnt, 1);
    sample();

    // STOP, view the single lap, then wrap back to STOP.
    pulse(1, 0, 0);
    expect_v("stop_state", FState, 2);
    expect_v("stop_en", FEn, 0);
    sample();
    set_live(50, 60, 40, 30);
    pulse(0, 0, 1);
    expect_v("view_state", FState, 3);
    expect_v("view_idx0", FView, 0);
    expect_disp("view_lap0", 37, 12, 5, 9);
    sample();
    pulse(0, 0, 1);
    expect_v("view_wrap_state", FState, 2);
    expect_v("view_wrap_idx", FView, 0);
    expect_disp("stop_live", 50, 60, 40, 30);
    sample();

    // Fill the memory, then overflow.
    pulse(1, 0, 0);
    expect_v("rerun_state", FState, 1);
    sample();
    set_live(1, 2, 3, 4);
    pulse(0, 0, 1);
    set_live(5, 6, 7, 8);
    pulse(0, 0, 1);
    expect_v("cap3_cnt", FLapCnt, 3);
    sample();
    set_live(9, 10, 11, 12);
    pulse(0, 0, 1);
    expect_v("cap4_cnt", FLapCnt, 4);
    expect_v("cap4_full", FFull, 1);
    expect_v("cap4_ovf", FOvf, 0);
    sample();
    set_live(13, 14, 15, 16);
    pulse(0, 0, 1);
    expect_v("ovf_cnt", FLapCnt, 4);
    expect_v("ovf_full", FFull, 1);
    expect_v("ovf_flag", FOvf, 1);
    sample();

    // Step through all four stored laps.
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    expect_v("v0_state", FState, 3);
    expect_v("v0_h", FDispH, 37);
    sample();
    pulse(0, 0, 1);
    expect_v("v1_idx", FView, 1);
    expect_disp("v1", 1, 2, 3, 4);
    sample();
    pulse(0, 0, 1);
    expect_v("v2_idx", FView, 2);
    expect_v("v2_h", FDispH, 5);
    sample();
    pulse(0, 0, 1);
    expect_v("v3_idx", FView, 3);
    expect_disp("v3", 9, 10, 11, 12);
    sample();
    pulse(0, 0, 1);
    expect_v("v_end_state", FState, 2);
    expect_v("v_end_idx", FView, 0);
    expect_v("v_end_h", FDispH, 13);
    sample();
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    expect_v("view_run_state", FState, 1);
    expect_v("view_run_idx", FView, 0);
    expect_v("view_run_en", FEn, 1);
    sample();
    pulse(1, 0, 0);
    expect_v("stop_ovf_held", FOvf, 1);
    sample();

    // All three keys at once in STOP: only clear acts.
    pulse(1, 1, 1);
    expect_v("tri_state", FState, 0);
    expect_v("tri_clr", FClr, 1);
    expect_v("tri_cnt", FLapCnt, 0);
    expect_v("tri_ovf", FOvf, 0);
    expect_v("tri_full", FFull, 0);
    expect_v("tri_en", FEn, 0);
    expect_v("tri_view", FView, 0);
    sample();
    expect_v("tri_clr_drop", FClr, 0);
    expect_v("tri_state2", FState, 0);
    sample();

    // STOP with no laps: lap ignored.
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    expect_v("empty_view_state", FState, 2);
    sample();
    pulse(1, 0, 0);

`ifdef LAP_BEEP_EN
    // Beep length and restart on a second capture.
    pulse(0, 0, 1);
    expect_v("beep_on", FBeep, 1);
    sample_now();
    repeat (20) begin
      @(posedge pls1k);
      @(posedge clk);
    end
    #1;
    expect_v("beep_at_20", FBeep, 1);
    sample_now();
    pulse(0, 0, 1);
    expect_v("beep_cap2_cnt", FLapCnt, 2);
    expect_v("beep_cap2_on", FBeep, 1);
    sample_now();
    repeat (49) begin
      @(posedge pls1k);
      @(posedge clk);
    end
    #1;
    expect_v("beep_restart_49", FBeep, 1);
    sample_now();
    @(posedge pls1k);
    @(posedge clk);
    #1;
    expect_v("beep_off_50", FBeep, 0);
    sample_now();
    pulse(0, 0, 1);
    expect_v("beep_mid", FBeep, 1);
    sample_now();
`else
    pulse(0, 0, 1);
`endif

    // Asynchronous reset mid-RUN, away from any clock edge.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    expect_v("arst_state", FState, 0);
    expect_v("arst_en", FEn, 0);
    expect_v("arst_beep", FBeep, 0);
    expect_v("arst_cnt", FLapCnt, 0);
    sample_now();

    // First edge after release accepts an event.
    @(negedge clk);
    #1 rst = 1'b1; start_stop = 1'b1;
    @(posedge clk);
    #1 start_stop = 1'b0;
    expect_v("post_rst_state", FState, 1);
    expect_v("post_rst_en", FEn, 1);
    sample_now();

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL unchecked: got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lap_ctl.md
LAP_CTL -- requirements
Module: lap_ctl

Interface
REQ-001 Parameter: LAP_DEPTH, 4, number of stored lap entries; legal 2..8.
REQ-002 Parameter: BEEP_MS, 50, beep length in pls1k rising edges; legal 1..255.
REQ-003 Port: clk  input  1  system clock (10 MHz).
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: pls1k  input  1  1 kHz square wave, synchronous to clk.
REQ-006 Port: start_stop / clear / lap  input  1 each  single-clk-cycle debounced key pulses.
REQ-007 Port: hcnt, tcnt  input  7 each; mcnt, scnt  input  6 each  live counter values.
REQ-008 Port: cnt_en  output  1  counter run enable.
REQ-009 Port: cnt_clr  output  1  counter clear pulse.
REQ-010 Port: disp_h, disp_t  output  7 each; disp_m, disp_s  output  6 each  values to BCD conversion.
REQ-011 Port: lap_cnt  output  4  stored laps, 0..LAP_DEPTH.
REQ-012 Port: view_idx  output  3  lap entry being displayed.
REQ-013 Port: lap_full, lap_ovf  output  1 each  memory full; sticky overflow.
REQ-014 Port: state  output  2  FSM state: IDLE=0, RUN=1, STOP=2, VIEW=3.
REQ-015 Port: beep  output  1  lap-capture beep request.

Function
REQ-016 At most one event acted on per cycle; priority clear > start_stop > lap; lower-priority pulses that cycle are discarded.
REQ-017 IDLE: start_stop -> RUN; clear -> cnt_clr pulse, stay IDLE; lap ignored.
REQ-018 RUN: start_stop -> STOP; clear ignored; lap -> capture (REQ-022).
REQ-019 STOP: start_stop -> RUN; clear -> IDLE with cnt_clr pulse, lap_cnt=0, lap_ovf=0; lap -> VIEW with view_idx=0 if lap_cnt>0, else ignored.
REQ-020 VIEW: lap -> view_idx+1; lap at view_idx=lap_cnt-1 -> STOP, view_idx=0; start_stop -> RUN, view_idx=0; clear -> as in STOP.
REQ-021 cnt_en registered, =1 exactly while state==RUN; event in cycle N -> cnt_en changes in cycle N+1.
REQ-022 Capture: live {hcnt,tcnt,mcnt,scnt} sampled in the lap-pulse cycle, written to entry lap_cnt; lap_cnt increments in cycle N+1.
REQ-023 Capture with lap_cnt==LAP_DEPTH: no write, lap_cnt unchanged, lap_ovf set in N+1, held until clear.
REQ-024 lap_full = (lap_cnt==LAP_DEPTH), combinational from lap_cnt.
REQ-025 cnt_clr: high for exactly one cycle, cycle N+1 after an accepted clear.
REQ-026 disp_*: combinational; live inputs in IDLE/RUN/STOP; lap entry view_idx in VIEW.
REQ-027 Lap memory contents not cleared on clear; entries >= lap_cnt are never displayed.

Reset
REQ-028 rst=0 asynchronously forces: state=IDLE, cnt_en=0, cnt_clr=0, lap_cnt=0, view_idx=0, lap_ovf=0, beep=0, beep counter=0, pls1k edge register=0.
REQ-029 Reset mid-RUN or mid-beep: outputs take reset values immediately; lap memory contents need not be reset.
REQ-030 First event accepted on the first clk edge after rst deasserts.

Configuration
REQ-031 Macro LAP_BEEP_EN defined: accepted capture (REQ-022) sets beep=1 in N+1; beep falls after BEEP_MS pls1k rising edges; capture during beep restarts the count; overflow (REQ-023) and clear do not beep.
REQ-032 LAP_BEEP_EN undefined: beep tied 0, no beep counter or pls1k edge logic.

Verification
REQ-033 Reset, start_stop at cycle 10 -> state=1, cnt_en=1 at cycle 11; start_stop again -> state=2, cnt_en=0 next cycle.
REQ-034 In RUN, hcnt=37 tcnt=12 mcnt=5 scnt=9, lap -> lap_cnt=1; STOP, lap -> state=3, disp_*=37/12/5/9, view_idx=0.
REQ-035 Five laps in RUN (depth 4) -> lap_cnt=4, lap_full=1, lap_ovf=1; STOP, clear -> cnt_clr 1 cycle, lap_cnt=0, lap_ovf=0, state=0.
REQ-036 start_stop, clear, lap same cycle in STOP -> clear only: state=0, no RUN, no VIEW.
REQ-037 LAP_BEEP_EN, BEEP_MS=50: lap in RUN -> beep high for 50 pls1k edges (~50 ms); second lap at 20 edges -> beep ends 50 edges after second lap.
REQ-038 rst=0 asserted mid-beep in RUN -> beep=0, cnt_en=0, state=0 without waiting for clk.
